// File: rtl/dmi_handler_if.sv
// dmi_handler_if
//   Request/response channels between dmi_handler and the debug module.
//   Parameter: ABITS - DMI address width.
//   Signals:
//     req_valid  handler -> DM   request valid
//     req_ready  DM -> handler   request accepted
//     req        handler -> DM   {addr[ABITS-1:0], data[31:0], op[1:0]}
//     resp_valid DM -> handler   response valid
//     resp_ready handler -> DM   response accepted
//     resp       DM -> handler   {data[31:0], resp[1:0]}
//   Modports: master (handler side), slave (DM side).
interface dmi_handler_if #(
  parameter int ABITS = 7
);
  logic             req_valid;
  logic             req_ready;
  logic [ABITS+33:0] req;
  logic             resp_valid;
  logic             resp_ready;
  logic [33:0]      resp;

  modport master (
    output req_valid, req, resp_ready,
    input  req_ready, resp_valid, resp
  );

  modport slave (
    input  req_valid, req, resp_ready,
    output req_ready, resp_valid, resp
  );
endinterface

// File: rtl/dmi_handler.sv
// dmi_handler
//   Runs one DMI transaction at a time between the UART TAP (level read/write
//   requests with a 4-phase done handshake) and the debug module channels.
//   Keeps a sticky dmistat-style error and aborts a stuck DM exchange after
//   TIMEOUT_CYCLES cycles.
//   Ports:
//     clk, rst_n      clock, synchronous active-low reset
//     dmi_read        TAP read request level
//     dmi_write       TAP write request level
//     dmi_cmd         {addr, data[31:0], op[1:0]} from TAP
//     dmi_result      {zeros, resp_data[31:0], resp[1:0]} to TAP
//     dmi_done        result valid, held until read/write both drop
//     dmi_hard_reset  abort and clear everything
//     dmi_reset       clear sticky error only
//     dmi_error       sticky status: 0 ok, 2 failed, 3 busy/timeout
//     dm              DM request/response channels (master side)
//
// state | meaning
// IDLE  | waiting for TAP request; stale DM responses are drained
// REQ   | request presented to DM, waiting for req_ready
// RESP  | waiting for DM response
// DONE  | result valid to TAP, waiting for request levels to drop
module dmi_handler #(
  parameter int ABITS          = 7,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dmi_read,
  input  logic              dmi_write,
  input  logic [ABITS+33:0] dmi_cmd,
  output logic [ABITS+33:0] dmi_result,
  output logic              dmi_done,
  input  logic              dmi_hard_reset,
  input  logic              dmi_reset,
  output logic [1:0]        dmi_error,
  dmi_handler_if.master     dm
);
  localparam int W  = ABITS + 34;
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]    state;
  logic [W-1:0]  req_q;
  logic [33:0]   result;
  logic [1:0]    error;
  logic [TW-1:0] timer;
  logic          timeout;
  logic [1:0]    new_err;

  // A handshake in the last allowed cycle takes priority over the abort.
  assign timeout = (timer == LAST) &&
                   ((state == REQ && !dm.req_ready) || (state == RESP && !dm.resp_valid));

  always_comb begin
    new_err = 2'd0;
    if (state == RESP && dm.resp_valid && dm.resp[1])
      new_err = dm.resp[1:0];
    else if (timeout)
      new_err = 2'd3;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || dmi_hard_reset) begin
      state  <= IDLE;
      req_q  <= '0;
      result <= '0;
      error  <= 2'd0;
      timer  <= '0;
    end else begin
      case (state)
        IDLE: begin
          timer <= '0;
          if (dmi_read || dmi_write) begin
            // Sticky error or a write with op nop/reserved completes without DM traffic.
            if (error != 2'd0 ||
                (!dmi_read && (dmi_cmd[1:0] == 2'd0 || dmi_cmd[1:0] == 2'd3))) begin
              state <= DONE;
            end else begin
              req_q <= dmi_read ? {dmi_cmd[W-1:34], 32'd0, 2'd1} : dmi_cmd;
              state <= REQ;
            end
          end
        end
        REQ: begin
          if (dm.req_ready) begin
            state <= RESP;
            if (timer != LAST) timer <= timer + 1'b1;
          end else if (timeout) begin
            result <= '0;
            timer  <= '0;
            state  <= DONE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RESP: begin
          if (dm.resp_valid) begin
            result <= dm.resp;
            timer  <= '0;
            state  <= DONE;
          end else if (timeout) begin
            result <= '0;
            timer  <= '0;
            state  <= DONE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          timer <= '0;
          if (!dmi_read && !dmi_write) state <= IDLE;
        end
      endcase

      if (dmi_reset)
        error <= 2'd0;
      else if (error == 2'd0)
        error <= new_err;
    end
  end

  assign dm.req_valid  = (state == REQ);
  assign dm.req        = req_q;
  // Held low while in reset so every output reads 0 then.
  assign dm.resp_ready = rst_n && (state == IDLE || state == RESP);
  assign dmi_done      = (state == DONE);
  assign dmi_result    = {{ABITS{1'b0}}, result};
  assign dmi_error     = error;
endmodule
